// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types, defaults and width derivation for the systolic GEMM core
// Purpose: operand/accumulator width defaults, the ACC_W derivation and the control FSM state type.
// Ports: none (package).
package gemm_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int K_MAX_DEF  = 16;

  // Product of two DATA_W signed values needs 2*DATA_W bits; summing up to
  // k_max of them grows the magnitude by at most clog2(k_max) bits.
  function automatic int acc_width(input int data_w, input int k_max);
    return 2 * data_w + $clog2(k_max);
  endfunction

  localparam int ACC_W_DEF = acc_width(DATA_W_DEF, K_MAX_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/gemm_pe.sv
// rtl/gemm_pe.sv - one output-stationary MAC processing element
// Purpose: accumulates a*b on enabled cycles and forwards a right / b down through registers.
// Ports: clk, rst (async, active-high); en (advance), clr (zero acc and pass registers);
//        a_in/b_in operands in; a_out/b_out registered pass-through; acc accumulator.
module gemm_pe
  import gemm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a_in * b_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/systolic_gemm_core.sv
// rtl/systolic_gemm_core.sv - output-stationary ROWS x COLS systolic matrix multiplier
// Purpose: C = A * B with per-run K, input skew, start/busy/done control and row-wise result drain.
// Ports: clk, rst (async, active-high); start/k_len run control; busy/done status;
//        in_valid/in_ready/a_col/b_row operand beats; out_valid/out_ready/out_row/out_data result rows.
module systolic_gemm_core
  import gemm_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  ROWS   = 4,
  parameter int  COLS   = 4,
  parameter int  K_MAX  = K_MAX_DEF,
  localparam int ACC_W  = acc_width(DATA_W, K_MAX),
  localparam int KL_W   = $clog2(K_MAX + 1),
  localparam int ROW_W  = $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KL_W-1:0]         k_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  a_col,
  input  logic [COLS*DATA_W-1:0]  b_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROW_W-1:0]        out_row,
  output logic [COLS*ACC_W-1:0]   out_data
);

  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int CNT_W     = $clog2(K_MAX + ROWS + COLS + 1);

  state_t            state, state_d;
  logic [KL_W-1:0]   k_eff;
  logic [CNT_W-1:0]  cnt;
  logic              en, clr, accept, drain_last;

  logic signed [DATA_W-1:0] a_src [ROWS];
  logic signed [DATA_W-1:0] b_src [COLS];
  logic signed [DATA_W-1:0] a_h   [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_v   [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc   [ROWS][COLS];

  always_comb begin
    state_d    = state;
    in_ready   = 1'b0;
    en         = 1'b0;
    clr        = 1'b0;
    accept     = 1'b0;
    drain_last = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = (k_len == '0) ? FLUSH : FEED;
        end
      end
      FEED: begin
        in_ready = 1'b1;
        accept   = in_valid;
        en       = in_valid;
        if (in_valid && (cnt + CNT_W'(1)) == CNT_W'(k_eff))
          state_d = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
      end
      FLUSH: begin
        // Degenerate 1x1 grid still spends one cycle here when entered with K=0.
        en = (FLUSH_LEN != 0);
        if (FLUSH_LEN == 0 || cnt == CNT_W'(FLUSH_LEN - 1))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready && out_row == ROW_W'(ROWS - 1)) begin
          drain_last = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k_eff   <= '0;
      cnt     <= '0;
      out_row <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_d;
      done  <= drain_last;
      // cnt counts accepted beats in FEED and elapsed cycles in FLUSH.
      if (state != state_d)
        cnt <= '0;
      else if ((state == FEED && accept) || state == FLUSH)
        cnt <= cnt + CNT_W'(1);
      if (state == IDLE && start)
        k_eff <= (k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len;
      if (state == DRAIN && out_ready)
        out_row <= drain_last ? '0 : out_row + ROW_W'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);

  // Zero operands are injected outside FEED so FLUSH pushes bubbles through the skew.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    assign a_src[gi] = (state == FEED) ? a_col[gi*DATA_W +: DATA_W] : '0;
    if (gi == 0) begin : g_direct
      assign a_h[gi][0] = a_src[gi];
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr [gi];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int s = 0; s < gi; s++) sr[s] <= '0;
        end else if (en) begin
          sr[0] <= a_src[gi];
          for (int s = 1; s < gi; s++) sr[s] <= sr[s-1];
        end
      end
      assign a_h[gi][0] = sr[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
    assign b_src[gj] = (state == FEED) ? b_row[gj*DATA_W +: DATA_W] : '0;
    if (gj == 0) begin : g_direct
      assign b_v[0][gj] = b_src[gj];
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr [gj];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int s = 0; s < gj; s++) sr[s] <= '0;
        end else if (en) begin
          sr[0] <= b_src[gj];
          for (int s = 1; s < gj; s++) sr[s] <= sr[s-1];
        end
      end
      assign b_v[0][gj] = sr[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      gemm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .a_in  (a_h[gi][gj]),
        .b_in  (b_v[gi][gj]),
        .a_out (a_h[gi][gj+1]),
        .b_out (b_v[gi+1][gj]),
        .acc   (acc[gi][gj])
      );
    end
  end

  always_comb begin
    out_data = '0;
    if (state == DRAIN)
      for (int j = 0; j < COLS; j++)
        out_data[j*ACC_W +: ACC_W] = acc[out_row][j];
  end

endmodule

// File: tb/tb_systolic_gemm_core.sv
// tb/tb_systolic_gemm_core.sv - self-checking bench for systolic_gemm_core (3x3 grid, K_MAX=16)
module tb_systolic_gemm_core;

  localparam int R = 3;
  localparam int C = 3;
  localparam int KM = 16;
  localparam int AW = 20;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [4:0]  k_len = '0;
  logic        busy, done;
  logic        in_valid = 0;
  logic        in_ready;
  logic [23:0] a_col = '0;
  logic [23:0] b_row = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [1:0]  out_row;
  logic [59:0] out_data;

  systolic_gemm_core #(.DATA_W(8), .ROWS(R), .COLS(C), .K_MAX(KM)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int accepted, unstable, tmo;
  int done_cnt = 0;
  int cyc = 0;
  int t_start = 0;
  int t_valid = 0;
  bit seen_valid = 0;
  logic signed [7:0] am [R][KM];
  logic signed [7:0] bm [KM][C];
  logic [59:0] exp_q [$];
  logic [59:0] got_data [R];
  logic [1:0]  got_row [R];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1 && !seen_valid) begin
      seen_valid = 1;
      t_valid = cyc;
    end
  end

  task automatic start_run(input int kl);
    start = 1;
    k_len = kl[4:0];
    t_start = cyc;
    seen_valid = 0;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic feed(input int nbeats, input int pct);
    int b = 0;
    int w = 0;
    bit hs;
    accepted = 0;
    while (b < nbeats && w < 1000 && in_ready) begin
      for (int i = 0; i < R; i++) a_col[i*8 +: 8] = am[i][b % KM];
      for (int j = 0; j < C; j++) b_row[j*8 +: 8] = bm[b % KM][j];
      in_valid = ($urandom_range(99) < pct);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      w++;
      if (hs) begin b++; accepted++; end
    end
    in_valid = 0;
  endtask

  task automatic push_expected(input int keff);
    logic signed [19:0] s;
    logic [59:0] row;
    for (int i = 0; i < R; i++) begin
      row = '0;
      for (int j = 0; j < C; j++) begin
        s = '0;
        for (int k = 0; k < keff; k++) s = s + am[i][k] * bm[k][j];
        row[j*AW +: AW] = s;
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic drain(input int stall);
    int w;
    unstable = 0;
    tmo = 0;
    for (int r = 0; r < R; r++) begin
      w = 0;
      out_ready = (stall == 0);
      while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
      if (!out_valid) begin tmo++; out_ready = 0; return; end
      got_row[r] = out_row;
      got_data[r] = out_data;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (!out_valid || out_row !== got_row[r] || out_data !== got_data[r]) unstable++;
      end
      out_ready = 1;
      @(posedge clk); #1;
    end
    out_ready = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    idle_cycles(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_row !== 2'd0) begin bad++; $display("FAIL reset_out_row got=%0d exp=0", out_row); end
    total++; if (out_data !== 60'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst = 0;
    idle_cycles(1);
  endtask

  task automatic test_identity;
    logic [59:0] e;
    for (int i = 0; i < R; i++) for (int k = 0; k < 3; k++) am[i][k] = 8'(3*i + k + 1);
    for (int k = 0; k < 3; k++) for (int j = 0; j < C; j++) bm[k][j] = (k == j) ? 8'sd1 : 8'sd0;
    done_cnt = 0;
    start_run(3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ident_busy got=%b exp=1", busy); end
    feed(3, 100);
    push_expected(3);
    drain(0);
    total++; if (tmo !== 0) begin bad++; $display("FAIL ident_timeout got=%0d exp=0", tmo); end
    total++; if (t_valid - t_start !== 8) begin bad++; $display("FAIL ident_latency got=%0d exp=8", t_valid - t_start); end
    for (int r = 0; r < R; r++) begin
      e = exp_q.pop_front();
      total++; if (got_data[r] !== e) begin bad++; $display("FAIL ident_row%0d got=%h exp=%h", r, got_data[r], e); end
      total++; if (got_row[r] !== 2'(r)) begin bad++; $display("FAIL ident_idx%0d got=%0d exp=%0d", r, got_row[r], r); end
    end
    total++; if (got_data[1] !== {20'd6, 20'd5, 20'd4}) begin bad++; $display("FAIL ident_const got=%h exp=%h", got_data[1], {20'd6, 20'd5, 20'd4}); end
    idle_cycles(2);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ident_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ident_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_max_k;
    logic [59:0] e;
    for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) am[i][k] = -8'sd128;
    for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) bm[k][j] = -8'sd128;
    start_run(16);
    feed(16, 100);
    push_expected(16);
    drain(0);
    total++; if (accepted !== 16) begin bad++; $display("FAIL maxk_beats got=%0d exp=16", accepted); end
    for (int r = 0; r < R; r++) begin
      e = exp_q.pop_front();
      total++; if (got_data[r] !== {3{20'd262144}}) begin bad++; $display("FAIL maxk_row%0d got=%h exp=%h", r, got_data[r], {3{20'd262144}}); end
      total++; if (got_data[r] !== e) begin bad++; $display("FAIL maxk_model%0d got=%h exp=%h", r, got_data[r], e); end
    end
    idle_cycles(2);
  endtask

  task automatic test_stalls;
    logic [59:0] e;
    for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) am[i][k] = 8'($urandom_range(255));
    for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) bm[k][j] = 8'($urandom_range(255));
    done_cnt = 0;
    start_run(4);
    feed(4, 50);
    push_expected(4);
    drain(3);
    total++; if (accepted !== 4) begin bad++; $display("FAIL stall_beats got=%0d exp=4", accepted); end
    total++; if (tmo !== 0) begin bad++; $display("FAIL stall_timeout got=%0d exp=0", tmo); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
    for (int r = 0; r < R; r++) begin
      e = exp_q.pop_front();
      total++; if (got_data[r] !== e) begin bad++; $display("FAIL stall_row%0d got=%h exp=%h", r, got_data[r], e); end
    end
    idle_cycles(2);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_k_bounds;
    logic [59:0] e;
    done_cnt = 0;
    start_run(0);
    feed(4, 100);
    push_expected(0);
    drain(0);
    total++; if (accepted !== 0) begin bad++; $display("FAIL k0_beats got=%0d exp=0", accepted); end
    for (int r = 0; r < R; r++) begin
      e = exp_q.pop_front();
      total++; if (got_data[r] !== e) begin bad++; $display("FAIL k0_row%0d got=%h exp=%h", r, got_data[r], e); end
    end
    idle_cycles(2);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL k0_done_cnt got=%0d exp=1", done_cnt); end
    for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) am[i][k] = 8'($urandom_range(255));
    for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) bm[k][j] = 8'($urandom_range(255));
    start_run(KM + 5);
    feed(KM + 5, 100);
    push_expected(KM);
    drain(0);
    total++; if (accepted !== KM) begin bad++; $display("FAIL kclamp_beats got=%0d exp=%0d", accepted, KM); end
    for (int r = 0; r < R; r++) begin
      e = exp_q.pop_front();
      total++; if (got_data[r] !== e) begin bad++; $display("FAIL kclamp_row%0d got=%h exp=%h", r, got_data[r], e); end
    end
    idle_cycles(2);
  endtask

  task automatic test_abort;
    logic [59:0] e;
    for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) am[i][k] = 8'sd7;
    for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) bm[k][j] = 8'sd9;
    done_cnt = 0;
    start_run(4);
    feed(2, 100);
    in_valid = 1;
    rst = 1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 60'd0) begin bad++; $display("FAIL abort_out_data got=%h exp=0", out_data); end
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
    idle_cycles(3);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done_cnt got=%0d exp=0", done_cnt); end
    for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) am[i][k] = 8'sd1;
    for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) bm[k][j] = 8'sd1;
    start_run(2);
    feed(2, 100);
    push_expected(2);
    drain(0);
    for (int r = 0; r < R; r++) begin
      e = exp_q.pop_front();
      total++; if (got_data[r] !== {3{20'd2}}) begin bad++; $display("FAIL abort_row%0d got=%h exp=%h", r, got_data[r], {3{20'd2}}); end
      total++; if (got_data[r] !== e) begin bad++; $display("FAIL abort_model%0d got=%h exp=%h", r, got_data[r], e); end
    end
    idle_cycles(2);
  endtask

  task automatic test_start_ignored;
    logic [59:0] e;
    for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) am[i][k] = 8'($urandom_range(255));
    for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) bm[k][j] = 8'($urandom_range(255));
    done_cnt = 0;
    start_run(3);
    feed(3, 100);
    push_expected(3);
    start = 1;
    k_len = 5'd7;
    drain(1);
    start = 0;
    total++; if (tmo !== 0) begin bad++; $display("FAIL ign_timeout got=%0d exp=0", tmo); end
    for (int r = 0; r < R; r++) begin
      e = exp_q.pop_front();
      total++; if (got_data[r] !== e) begin bad++; $display("FAIL ign_row%0d got=%h exp=%h", r, got_data[r], e); end
    end
    idle_cycles(3);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b exp=0", busy); end
  endtask

  initial begin
    #1;
    test_reset();
    test_identity();
    test_max_k();
    test_stalls();
    test_k_bounds();
    test_abort();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
